// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes, data-RAM
// freeze with a watchdog that halts the core, and a saturating stall counter.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_load,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_branch_taken,
  input  logic             mem_ram_req,
  input  logic             ram_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state,
  output logic [7:0]       dbg_wait_cnt
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [7:0]       TIMEOUT_M1 = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_nxt;
  logic             r_halt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_lu;
  logic w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
  logic w_if_id_flush, w_id_ex_flush, w_mem_wb_flush;

  assign w_lu = ex_load && (ex_rd_addr != 5'd0) &&
                ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                 (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

  always_comb begin
    w_next         = r_state;
    w_wait_nxt     = r_wait_cnt;
    w_pc_en        = 1'b0;
    w_if_id_en     = 1'b0;
    w_id_ex_en     = 1'b0;
    w_ex_mem_en    = 1'b0;
    w_mem_wb_en    = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_mem_wb_flush = 1'b0;
    case (r_state)
      S_RUN: begin
        if (mem_ram_req && !ram_ready) begin
          // Freeze; MEM/WB takes a bubble so the writeback is not repeated.
          w_mem_wb_en    = 1'b1;
          w_mem_wb_flush = 1'b1;
          w_next         = S_WAIT;
          w_wait_nxt     = 8'd0;
        end else if (ex_branch_taken) begin
          {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 5'b11111;
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end else if (w_lu) begin
          {w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 3'b111;
          w_id_ex_flush = 1'b1;
        end else begin
          {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 5'b11111;
        end
      end
      S_WAIT: begin
        if (!ram_ready) begin
          w_mem_wb_en    = 1'b1;
          w_mem_wb_flush = 1'b1;
          w_wait_nxt     = r_wait_cnt + 8'd1;
          if (r_wait_cnt == TIMEOUT_M1) w_next = S_HALT;
        end else begin
          {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 5'b11111;
          w_next = S_RUN;
        end
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= 8'd0;
      r_halt      <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_nxt;
      r_halt     <= (w_next == S_HALT);
      if (!w_pc_en && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Reset overrides the state decode so every control drops immediately.
  assign pc_en        = w_pc_en        & ~rst;
  assign if_id_en     = w_if_id_en     & ~rst;
  assign id_ex_en     = w_id_ex_en     & ~rst;
  assign ex_mem_en    = w_ex_mem_en    & ~rst;
  assign mem_wb_en    = w_mem_wb_en    & ~rst;
  assign if_id_flush  = w_if_id_flush  & ~rst;
  assign id_ex_flush  = w_id_ex_flush  & ~rst;
  assign mem_wb_flush = w_mem_wb_flush & ~rst;

  assign halt         = r_halt;
  assign stall_cnt    = r_stall_cnt;
  assign dbg_state    = r_state;
  assign dbg_wait_cnt = r_wait_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: load-use, branch priority, memory wait,
// watchdog timeout, counter saturation and asynchronous reset.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;

  localparam logic [7:0] C_RUN    = 8'hF8;  // all enables, no flush
  localparam logic [7:0] C_MEM    = 8'h09;  // frozen, MEM/WB bubble
  localparam logic [7:0] C_BRANCH = 8'hFE;
  localparam logic [7:0] C_LU     = 8'h3A;
  localparam logic [7:0] C_OFF    = 8'h00;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic             id_rs1_used, id_rs2_used, ex_load, ex_branch_taken;
  logic             mem_ram_req, ram_ready;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_flush, mem_wb_flush, halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       dbg_state;
  logic [7:0]       dbg_wait_cnt;
  logic [7:0]       ctl;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, mem_wb_flush};

  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_load(ex_load), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken),
    .mem_ram_req(mem_ram_req), .ram_ready(ram_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .halt(halt), .stall_cnt(stall_cnt),
    .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_load = 1'b0;
    ex_branch_taken = 1'b0; mem_ram_req = 1'b0; ram_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check("rst_ctl", ctl, C_OFF);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    ex_load = 1'b1; ex_rd_addr = rd;
    id_rs1_addr = rs1; id_rs1_used = u1;
    id_rs2_addr = rs2; id_rs2_used = u2;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #2;
    check("reset_ctl", ctl, C_OFF);
    check("reset_halt", halt, 1'b0);
    check("reset_cnt", stall_cnt, 0);
    check("reset_state", dbg_state, ST_RUN);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_ctl", ctl, C_RUN);
    step();
    check("idle_cnt", stall_cnt, 0);

    // load-use on rs1, then rs2, then non-hazard variants
    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    #1 check("lu_rs1_ctl", ctl, C_LU);
    step();
    clear_inputs();
    #1 check("lu_rs1_after", ctl, C_RUN);
    check("lu_rs1_cnt", stall_cnt, 1);
    set_lu(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
    #1 check("lu_rs2_ctl", ctl, C_LU);
    step();
    clear_inputs();
    check("lu_rs2_cnt", stall_cnt, 2);
    set_lu(5'd9, 5'd9, 1'b0, 5'd1, 1'b1);
    #1 check("lu_unused_ctl", ctl, C_RUN);
    set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1 check("lu_rd0_ctl", ctl, C_RUN);
    step();
    check("lu_rd0_cnt", stall_cnt, 2);

    // branch beats load-use
    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    ex_branch_taken = 1'b1;
    #1 check("br_lu_ctl", ctl, C_BRANCH);
    step();
    clear_inputs();
    check("br_lu_cnt", stall_cnt, 2);

    // RAM ready in the request cycle: no stall
    mem_ram_req = 1'b1; ram_ready = 1'b1;
    #1 check("mem_rdy_ctl", ctl, C_RUN);
    step();
    clear_inputs();
    check("mem_rdy_cnt", stall_cnt, 2);

    // memory wait: 3 not-ready cycles, then ready
    pulse_reset();
    exp_q = '{C_MEM, C_MEM, C_MEM, C_RUN};
    mem_ram_req = 1'b1; ram_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) ex_branch_taken = 1'b1;
      if (i == 3) ram_ready = 1'b1;
      #1 check($sformatf("memwait_ctl%0d", i), ctl, exp_q.pop_front());
      if (i == 2) check("memwait_wcnt", dbg_wait_cnt, 8'd1);
      step();
    end
    clear_inputs();
    check("memwait_state", dbg_state, ST_RUN);
    check("memwait_cnt", stall_cnt, 3);

    // watchdog timeout with MEM_TIMEOUT = 4
    pulse_reset();
    mem_ram_req = 1'b1; ram_ready = 1'b0;
    #1 check("to_t0_ctl", ctl, C_MEM);
    for (int t = 1; t <= 4; t++) begin
      step();
      check($sformatf("to_t%0d_state", t), dbg_state, ST_WAIT);
      check($sformatf("to_t%0d_halt", t), halt, 1'b0);
    end
    step();
    check("to_t5_halt", halt, 1'b1);
    check("to_t5_state", dbg_state, ST_HALT);
    check("to_t5_ctl", ctl, C_OFF);
    check("to_t5_cnt", stall_cnt, 5);
    ram_ready = 1'b1;
    #1 check("to_rdy_ctl", ctl, C_OFF);
    step();
    check("to_sticky_halt", halt, 1'b1);
    check("to_sticky_cnt", stall_cnt, 6);
    clear_inputs();
    rst = 1'b1;
    #1;
    check("to_rst_halt", halt, 1'b0);
    check("to_rst_cnt", stall_cnt, 0);
    check("to_rst_state", dbg_state, ST_RUN);
    rst = 1'b0;

    // saturation: counter keeps counting in HALT and stops at 15
    step();
    mem_ram_req = 1'b1; ram_ready = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt", stall_cnt, 15);
    check("sat_halt", halt, 1'b1);

    // asynchronous reset mid-WAIT
    clear_inputs();
    pulse_reset();
    mem_ram_req = 1'b1; ram_ready = 1'b0;
    step();
    step();
    check("aw_state", dbg_state, ST_WAIT);
    check("aw_wcnt", dbg_wait_cnt, 8'd1);
    check("aw_ctl", ctl, C_MEM);
    #1 rst = 1'b1;
    #1;
    check("aw_rst_ctl", ctl, C_OFF);
    check("aw_rst_state", dbg_state, ST_RUN);
    check("aw_rst_wcnt", dbg_wait_cnt, 8'd0);
    rst = 1'b0;
    clear_inputs();
    #1 check("aw_rel_ctl", ctl, C_RUN);
    step();
    check("aw_rel_state", dbg_state, ST_RUN);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
